// File: rtl/led_pattern_gen_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
// Imported by the RTL and by the bench.
package led_pattern_gen_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PWM   = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_COMMIT = 1'b1
   } cfg_state_e;

   // Channel-select width; a single channel still needs one select bit.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Config port of the LED pattern generator: valid/ready request carrying
// channel, mode, period and duty.
interface led_pattern_gen_if
   import led_pattern_gen_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int PER_W  = 8
) ();

   localparam int CH_W = ch_width(NUM_CH);

   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [MODE_W-1:0] cfg_mode;
   logic [PER_W-1:0]  cfg_period;
   logic [PER_W-1:0]  cfg_duty;

   modport master (
      output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
      output cfg_ready
   );

endinterface

// File: rtl/led_pattern_ch.sv
// One LED channel: mode/period/duty/phase registers and the registered
// output for OFF, ON, BLINK and PWM.
module led_pattern_ch
   import led_pattern_gen_pkg::*;
#(
   parameter int PER_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_tick,
   input  logic             i_commit,
   input  mode_e            i_mode,
   input  logic [PER_W-1:0] i_period,
   input  logic [PER_W-1:0] i_duty,
   output logic             o_led
);

   mode_e            r_mode;
   logic [PER_W-1:0] r_period;
   logic [PER_W-1:0] r_duty;
   logic [PER_W-1:0] r_phase;
   logic             r_blink;
   logic             r_led;

   logic w_wrap;
   logic w_led_nxt;

   assign w_wrap = (r_phase == r_period);

   // A commit outranks a coincident tick: phase restarts and no toggle happens.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode   <= MODE_OFF;
         r_period <= '0;
         r_duty   <= '0;
         r_phase  <= '0;
         r_blink  <= 1'b0;
      end else if (i_commit) begin
         r_mode   <= i_mode;
         r_period <= i_period;
         r_duty   <= i_duty;
         r_phase  <= '0;
         r_blink  <= 1'b0;
      end else if (i_tick) begin
         r_phase <= w_wrap ? '0 : r_phase + 1'b1;
         if (w_wrap && (r_mode == MODE_BLINK)) begin
            r_blink <= ~r_blink;
         end
      end
   end

   always_comb begin
      w_led_nxt = 1'b0;
      case (r_mode)
         MODE_OFF:   w_led_nxt = 1'b0;
         MODE_ON:    w_led_nxt = 1'b1;
         MODE_BLINK: w_led_nxt = r_blink;
         MODE_PWM:   w_led_nxt = (r_phase < r_duty);
         default:    w_led_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_led <= 1'b0;
      end else begin
         r_led <= w_led_nxt;
      end
   end

   assign o_led = r_led;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler, config staging with
// a two-state accept/commit handshake, and NUM_CH pattern channels.
module led_pattern_gen
   import led_pattern_gen_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int PRE_W    = 24,
   parameter int PRESCALE = 1000,
   parameter int PER_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   led_pattern_gen_if.slave  cfg,
   output logic [NUM_CH-1:0] led,
   output logic              tick
);

   localparam int              CH_W     = ch_width(NUM_CH);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] r_pre_cnt;
   logic             r_tick;

   cfg_state_e       r_state;
   cfg_state_e       w_state_nxt;
   logic             w_accept;
   logic             w_commit;

   logic [CH_W-1:0]  r_stg_ch;
   mode_e            r_stg_mode;
   logic [PER_W-1:0] r_stg_period;
   logic [PER_W-1:0] r_stg_duty;

   logic [NUM_CH-1:0] w_ch_commit;
   logic [NUM_CH-1:0] w_led;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pre_cnt <= '0;
         r_tick    <= 1'b0;
      end else if (r_pre_cnt == PRE_LAST) begin
         r_pre_cnt <= '0;
         r_tick    <= 1'b1;
      end else begin
         r_pre_cnt <= r_pre_cnt + 1'b1;
         r_tick    <= 1'b0;
      end
   end

   assign tick = r_tick;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cfg.cfg_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign cfg.cfg_ready = (r_state == ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stg_ch     <= '0;
         r_stg_mode   <= MODE_OFF;
         r_stg_period <= '0;
         r_stg_duty   <= '0;
      end else if (w_accept) begin
         r_stg_ch     <= cfg.cfg_ch;
         r_stg_mode   <= mode_e'(cfg.cfg_mode);
         r_stg_period <= cfg.cfg_period;
         r_stg_duty   <= cfg.cfg_duty;
      end
   end

   // Out-of-range channel numbers match no decode line, so their commit is dropped.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_ch_commit[g] = w_commit && (r_stg_ch == CH_W'(g));

      led_pattern_ch #(
         .PER_W (PER_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_tick   (r_tick),
         .i_commit (w_ch_commit[g]),
         .i_mode   (r_stg_mode),
         .i_period (r_stg_period),
         .i_duty   (r_stg_duty),
         .o_led    (w_led[g])
      );
   end

   assign led = w_led;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed scoreboard bench for led_pattern_gen (PRESCALE=4, NUM_CH=4) plus a
// 3-channel instance for the out-of-range channel case.
`timescale 1ns/100ps
module tb_led_pattern_gen;
   import led_pattern_gen_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] led;
   logic       tick;
   logic [2:0] led3;
   logic       tick3;

   always #1 clk = ~clk;

   led_pattern_gen_if #(.NUM_CH(4), .PER_W(8)) cfg_if ();
   led_pattern_gen_if #(.NUM_CH(3), .PER_W(8)) cfg3_if ();

   led_pattern_gen #(.NUM_CH(4), .PRE_W(24), .PRESCALE(4), .PER_W(8)) dut (
      .clk (clk), .rst (rst), .cfg (cfg_if.slave), .led (led), .tick (tick)
   );

   led_pattern_gen #(.NUM_CH(3), .PRE_W(24), .PRESCALE(4), .PER_W(8)) dut3 (
      .clk (clk), .rst (rst), .cfg (cfg3_if.slave), .led (led3), .tick (tick3)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;

   sb_t sb[$];
   int  vectors     = 0;
   int  miscompares = 0;

   task automatic push(input string tag, input logic [31:0] v);
      sb_t it;
      it.tag = tag;
      it.exp = v;
      sb.push_back(it);
   endtask

   task automatic chk(input logic [31:0] obs);
      sb_t it;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty: observed %0h, required an expected entry", obs);
      end else begin
         it = sb.pop_front();
         assert (obs === it.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", it.tag, obs, it.exp);
         end
      end
   endtask

   // Caller sits at a negedge; returns at the negedge after the commit+1 edge.
   task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                            input logic [7:0] per, input logic [7:0] duty);
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_ch     = ch;
      cfg_if.cfg_mode   = mode;
      cfg_if.cfg_period = per;
      cfg_if.cfg_duty   = duty;
      push("rdy_before_accept", 1);
      push("rdy_after_accept", 0);
      push("rdy_after_commit", 1);
      chk(32'(cfg_if.cfg_ready));
      @(negedge clk);
      chk(32'(cfg_if.cfg_ready));
      cfg_if.cfg_valid = 1'b0;
      @(negedge clk);
      chk(32'(cfg_if.cfg_ready));
      @(negedge clk);
   endtask

   // Samples held by led[b] from now until it changes; ends on the first new sample.
   task automatic run_len(input int b, output logic v, output int len);
      v   = led[b];
      len = 0;
      while (led[b] === v && len < 400) begin
         @(negedge clk);
         len++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic v;
      int   len;
      int   cnt;
      int   n;

      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_ch     = '0;
      cfg_if.cfg_mode   = '0;
      cfg_if.cfg_period = '0;
      cfg_if.cfg_duty   = '0;
      cfg3_if.cfg_valid  = 1'b0;
      cfg3_if.cfg_ch     = '0;
      cfg3_if.cfg_mode   = '0;
      cfg3_if.cfg_period = '0;
      cfg3_if.cfg_duty   = '0;

      // 1. reset state and prescaler cadence
      repeat (100) @(negedge clk);
      push("rst_led", 0);   chk(32'(led));
      push("rst_ready", 1); chk(32'(cfg_if.cfg_ready));
      push("rst_tick", 0);  chk(32'(tick));
      rst = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         push($sformatf("tick_c%0d", k), ((k % 4) == 0) ? 1 : 0);
         chk(32'(tick));
      end

      // 2. ch0 BLINK period=2
      cfg_write(2'd0, MODE_BLINK, 8'd2, 8'd0);
      push("blink_start_val", 0); run_len(0, v, len); chk(32'(v));
      push("blink_hi_val", 1);    push("blink_hi_len", 12);
      run_len(0, v, len); chk(32'(v)); chk(32'(len));
      push("blink_lo_val", 0);    push("blink_lo_len", 12);
      run_len(0, v, len); chk(32'(v)); chk(32'(len));
      push("blink_others_off", 0); chk(32'(led[3:1]));

      // 3. ch1 PWM period=9 duty=3, then duty=0 and duty=10
      cfg_write(2'd1, MODE_PWM, 8'd9, 8'd3);
      push("pwm_start_val", 1); run_len(1, v, len); chk(32'(v));
      push("pwm_lo_val", 0);    push("pwm_lo_len", 28);
      run_len(1, v, len); chk(32'(v)); chk(32'(len));
      push("pwm_hi_val", 1);    push("pwm_hi_len", 12);
      run_len(1, v, len); chk(32'(v)); chk(32'(len));

      cfg_write(2'd1, MODE_PWM, 8'd9, 8'd0);
      cnt = 0;
      for (int k = 0; k < 48; k++) begin
         if (led[1] !== 1'b0) cnt++;
         @(negedge clk);
      end
      push("pwm_duty0_highs", 0); chk(32'(cnt));

      cfg_write(2'd1, MODE_PWM, 8'd9, 8'd10);
      cnt = 0;
      for (int k = 0; k < 48; k++) begin
         if (led[1] !== 1'b1) cnt++;
         @(negedge clk);
      end
      push("pwm_duty10_lows", 0); chk(32'(cnt));

      // 4. back-to-back requests with cfg_valid held
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_ch     = 2'd2;
      cfg_if.cfg_mode   = MODE_ON;
      cfg_if.cfg_period = 8'd0;
      cfg_if.cfg_duty   = 8'd0;
      push("b2b_rdy0", 1); chk(32'(cfg_if.cfg_ready));
      @(negedge clk);
      push("b2b_rdy1", 0); chk(32'(cfg_if.cfg_ready));
      push("b2b_led2_a1", 0); chk(32'(led[2]));
      cfg_if.cfg_ch = 2'd3;
      @(negedge clk);
      push("b2b_rdy2", 1); chk(32'(cfg_if.cfg_ready));
      push("b2b_led2_a1p", 0); chk(32'(led[2]));
      @(negedge clk);
      push("b2b_rdy3", 0); chk(32'(cfg_if.cfg_ready));
      push("b2b_led2_a2", 1); chk(32'(led[2]));
      cfg_if.cfg_valid = 1'b0;
      @(negedge clk);
      push("b2b_rdy4", 1); chk(32'(cfg_if.cfg_ready));
      push("b2b_led3_b1", 0); chk(32'(led[3]));
      @(negedge clk);
      push("b2b_led3_b2", 1); chk(32'(led[3]));

      // 5. commit on ch0 coincident with a tick
      n = 0;
      while (tick !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      push("coinc_tick_seen", 1); chk(32'(tick));
      repeat (3) @(negedge clk);
      cfg_write(2'd0, MODE_BLINK, 8'd1, 8'd0);
      push("coinc_led0_a2", 0); chk(32'(led[0]));
      for (int k = 3; k <= 9; k++) begin
         @(negedge clk);
         push($sformatf("coinc_led0_a%0d", k), 0);
         chk(32'(led[0]));
      end
      @(negedge clk);
      push("coinc_led0_a10", 1); chk(32'(led[0]));

      // 5b. out-of-range channel on the 3-channel instance
      cfg3_if.cfg_valid  = 1'b1;
      cfg3_if.cfg_ch     = 2'd3;
      cfg3_if.cfg_mode   = MODE_ON;
      cfg3_if.cfg_period = 8'd0;
      cfg3_if.cfg_duty   = 8'd0;
      push("oor_rdy0", 1); chk(32'(cfg3_if.cfg_ready));
      @(negedge clk);
      push("oor_rdy1", 0); chk(32'(cfg3_if.cfg_ready));
      cfg3_if.cfg_valid = 1'b0;
      @(negedge clk);
      push("oor_rdy2", 1); chk(32'(cfg3_if.cfg_ready));
      repeat (4) @(negedge clk);
      push("oor_led3", 0); chk(32'(led3));

      // 6. asynchronous reset mid-operation
      push("pre_rst_led31", 3'b111); chk(32'(led[3:1]));
      #0.3 rst = 1'b0;
      #0.2;
      push("async_rst_led", 0);   chk(32'(led));
      push("async_rst_ready", 1); chk(32'(cfg_if.cfg_ready));
      push("async_rst_tick", 0);  chk(32'(tick));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (led !== 4'b0000) cnt++;
         if (k <= 8) begin
            push($sformatf("rel_tick_c%0d", k), ((k % 4) == 0) ? 1 : 0);
            chk(32'(tick));
         end
      end
      push("post_rst_led_nonzero", 0); chk(32'(cnt));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
